qos_stat_overlay: RTL and testbench
===================================

# qos_stat_overlay

Parametrised VGA overlay that renders the QoS buffer statistics (dropped, received and transmitted counts, or any NUM_STATS × NUM_CH counter grid) as decimal digits. Once per frame it snapshots the counters and converts them to BCD with a sequential shift-add-3 engine into a double-buffered digit store. It then serves glyph-ROM addresses and digit codes to the pixel mux with a fixed 2-cycle latency. It sits between the `overall` statistics outputs, `vga_sync` and a `pure_numbers` glyph ROM. It replaces the hard-wired table/column decode.

## Interface
Parameters:
- NUM_CH, 4, channels (columns)
- NUM_STATS, 3, statistic rows
- CNT_W, 8, counter width
- DIGITS, 3, displayed decimal digits per counter
- BLANK_LZ, 1, 1 = suppress leading zeros (least-significant digit always shown)
- ORIGIN_X / ORIGIN_Y, 366 / 154, lower-limit x/y of cell (stat 0, ch 0, digit 0)
- COL_PITCH / ROW_PITCH, 60 / 95, pixel spacing between channels / stat rows
- CELL_W / CELL_H, 10 / 16, digit cell size (glyph is CELL_W-1 × CELL_H-1)

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-high reset
- on  in  1  active-video flag from vga_sync
- new_frame  in  1  one-cycle pulse at start of vertical blanking
- x_loc, y_loc  in  10 each  current pixel coordinates
- stats  in  NUM_STATS·NUM_CH·CNT_W  entry e = s·NUM_CH + c occupies bits [e·CNT_W +: CNT_W]
- pixel_active  out  1  current pixel lies inside a visible digit cell
- digit  out  4  BCD digit for the glyph ROM
- glyph_addr  out  8  glyph ROM pixel address
- busy  out  1  conversion in progress
- skip_count  out  8  saturating count of new_frame pulses ignored while busy

## Operation
- Converter FSM states: IDLE, LOAD, SHIFT, WRITE, SWAP.
- IDLE: on new_frame, capture all of stats into the snapshot register, set e=0, go to LOAD. If new_frame arrives while not IDLE, ignore it and increment skip_count (saturate at 255).
- LOAD: copy snapshot entry e into the shift register and clear the BCD accumulator. Set sat = (value > 10^DIGITS − 1).
- SHIFT: CNT_W cycles of double-dabble. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left 1. The accumulator holds enough digits for 2^CNT_W − 1.
- WRITE: store DIGITS nibbles into the back bank at entry e; if sat, store all 9s. If e = last, go to SWAP; otherwise e+1 and LOAD.
- SWAP: toggle the front/back bank select, go to IDLE.
- Pixel path, stage 1 (registered):
  - Cell for (s, c, d) has lower limits lx = ORIGIN_X + c·COL_PITCH + d·CELL_W and ly = ORIGIN_Y + s·ROW_PITCH.
  - Hit when lx < x_loc < lx+CELL_W and ly < y_loc < ly+CELL_H (strict bounds), and on = 1.
  - Register hit, entry, digit index d (0 = most significant), and addr = (y_loc−ly−1)·(CELL_W−1) + (x_loc−lx−1).
- Pixel path, stage 2 (registered):
  - Read the digit from the front bank and output digit and glyph_addr.
  - pixel_active = hit AND NOT blanked.
  - Blanked when BLANK_LZ=1, d < DIGITS−1, and all digits 0..d of that entry are zero.
- With no hit, outputs are digit=0, glyph_addr=0, pixel_active=0.

## Timing
- Reset values: all outputs 0; both banks cleared to 0; FSM in IDLE; bank select 0; snapshot cleared.
- Conversion takes CNT_W+2 cycles per entry (LOAD + SHIFT×CNT_W + WRITE).
- busy rises the cycle after new_frame and falls the cycle SWAP is taken. Total busy = NUM_STATS·NUM_CH·(CNT_W+2)+1 cycles, which is 121 with defaults and must fit in vertical blanking.
- The front bank never changes mid-frame except at SWAP. The display shows the previous frame's values until SWAP.
- Pixel latency is exactly 2 clk from x_loc/y_loc/on to the outputs. Stage 2 sees on=0 as no hit.
- new_frame coincident with SWAP is ignored and counted in skip_count.
- A stats change after the capture cycle does not affect the current conversion.
- Reset mid-conversion aborts immediately. Both banks return to 0 and no SWAP occurs.

## Test plan
- Reset, then pixel sweep: pixel_active only on the least-significant cell of each entry, showing digit 0. Both busy and skip_count read 0.
- Load stat0/ch0 = 255 and pulse new_frame. busy must be high for 121 cycles. After the swap, the three cells of the first cell group show digits 2, 5, 5.
- Value 7 with BLANK_LZ=1: only d=2 is active, showing 7. The same value with BLANK_LZ=0 shows 0, 0, 7.
- Pulse new_frame again 10 cycles after the first: skip_count becomes 1, busy length is unchanged, and the results match the first snapshot.
- Boundaries, with CNT_W=12 and DIGITS=3: x=lx is inactive; (lx+1, ly+1) gives addr 0; (lx+9, ly+15) gives addr 134; x=lx+10 is inactive. Value 1500 displays 9, 9, 9.
- Assert rst 40 cycles into a conversion: busy drops at once and all cells read 0. A following new_frame completes normally.

Source files
------------

// File: rtl/qos_stat_overlay.sv
// qos_stat_overlay: renders a NUM_STATS x NUM_CH grid of counters as decimal digits on VGA.
// Once per frame the counters are snapshotted and converted to BCD (shift-add-3) into the back
// bank of a double-buffered digit store. The front bank feeds a 2-stage pixel pipeline that
// serves digit codes and glyph-ROM addresses.
//
// Ports:
//   clk, rst        pixel clock, asynchronous active-high reset
//   on              active-video flag
//   new_frame       one-cycle pulse at start of vertical blanking
//   x_loc, y_loc    current pixel coordinates
//   stats           counter grid, entry e = s*NUM_CH + c at [e*CNT_W +: CNT_W]
//   pixel_active    pixel lies inside a visible (non-blanked) digit cell
//   digit           BCD digit for the glyph ROM
//   glyph_addr      glyph ROM pixel address
//   busy            conversion in progress
//   skip_count      saturating count of new_frame pulses ignored while busy
module qos_stat_overlay #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NUM_STATS = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned BLANK_LZ  = 1,
  parameter int unsigned ORIGIN_X  = 366,
  parameter int unsigned ORIGIN_Y  = 154,
  parameter int unsigned COL_PITCH = 60,
  parameter int unsigned ROW_PITCH = 95,
  parameter int unsigned CELL_W    = 10,
  parameter int unsigned CELL_H    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              on,
  input  logic                              new_frame,
  input  logic [9:0]                        x_loc,
  input  logic [9:0]                        y_loc,
  input  logic [NUM_STATS*NUM_CH*CNT_W-1:0] stats,
  output logic                              pixel_active,
  output logic [3:0]                        digit,
  output logic [7:0]                        glyph_addr,
  output logic                              busy,
  output logic [7:0]                        skip_count
);

  // Decimal digits needed to hold 2^w - 1.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam int unsigned NumEnt  = NUM_STATS * NUM_CH;
  localparam int unsigned EntW    = (NumEnt > 1) ? $clog2(NumEnt) : 1;
  localparam int unsigned DigW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW    = $clog2(CNT_W + 1);
  localparam int unsigned AccDig  = (dec_digits(CNT_W) > DIGITS) ? dec_digits(CNT_W) : DIGITS;
  localparam int unsigned AccW    = 4 * AccDig;
  localparam longint unsigned MaxShow = pow10(DIGITS) - 64'd1;

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StWrite, StSwap} state_e;

  state_e                              state_q, state_d;
  logic [NUM_STATS*NUM_CH*CNT_W-1:0]   snap_q;
  logic [EntW-1:0]                     ent_q;
  logic [CntW-1:0]                     bit_q;
  logic [CNT_W-1:0]                    sh_q, load_val;
  logic [AccW-1:0]                     bcd_q, bcd_adj;
  logic                                sat_q;
  logic                                sel_q;   // front bank index
  logic [7:0]                          skip_q;
  logic [3:0]                          bank_q [2][NumEnt][DIGITS];

  // ---------------------------------------------------------------------------------------------
  // Converter FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (new_frame) state_d = StLoad;
      StLoad:  state_d = StShift;
      StShift: if (bit_q == CntW'(CNT_W - 1)) state_d = StWrite;
      StWrite: state_d = (ent_q == EntW'(NumEnt - 1)) ? StSwap : StLoad;
      StSwap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign load_val = snap_q[int'(ent_q) * CNT_W +: CNT_W];

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(AccDig); i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      ent_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      bcd_q  <= '0;
      sat_q  <= 1'b0;
      sel_q  <= 1'b0;
      skip_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < int'(NumEnt); e++) begin
          for (int d = 0; d < int'(DIGITS); d++) bank_q[b][e][d] <= 4'd0;
        end
      end
    end else begin
      // Pulses arriving outside IDLE (including the SWAP cycle) are dropped and counted.
      if (new_frame && state_q != StIdle && skip_q != 8'hFF) skip_q <= skip_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          if (new_frame) begin
            snap_q <= stats;
            ent_q  <= '0;
          end
        end
        StLoad: begin
          sh_q  <= load_val;
          bcd_q <= '0;
          bit_q <= '0;
          sat_q <= (64'(load_val) > MaxShow);
        end
        StShift: begin
          {bcd_q, sh_q} <= {bcd_adj, sh_q} << 1;
          bit_q         <= bit_q + CntW'(1);
        end
        StWrite: begin
          // Digit index 0 is the most significant displayed digit.
          for (int d = 0; d < int'(DIGITS); d++) begin
            bank_q[~sel_q][ent_q][d] <= sat_q ? 4'd9 : bcd_q[(DIGITS - 1 - d) * 4 +: 4];
          end
          if (ent_q != EntW'(NumEnt - 1)) ent_q <= ent_q + EntW'(1);
        end
        StSwap:  sel_q <= ~sel_q;
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign skip_count = skip_q;

  // ---------------------------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------------------------
  logic            hit1_d, hit1_q;
  logic [EntW-1:0] ent1_d, ent1_q;
  logic [DigW-1:0] dig1_d, dig1_q;
  logic [7:0]      addr1_d, addr1_q;
  logic [3:0]      rd_dig;
  logic            lead_zero, blanked;

  // Stage 1: locate the cell under the pixel (strict bounds on all four sides).
  always_comb begin
    int xi, yi, lx, ly;
    hit1_d  = 1'b0;
    ent1_d  = '0;
    dig1_d  = '0;
    addr1_d = '0;
    xi      = int'(x_loc);
    yi      = int'(y_loc);
    lx      = 0;
    ly      = 0;
    for (int s = 0; s < int'(NUM_STATS); s++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        for (int d = 0; d < int'(DIGITS); d++) begin
          lx = int'(ORIGIN_X) + c * int'(COL_PITCH) + d * int'(CELL_W);
          ly = int'(ORIGIN_Y) + s * int'(ROW_PITCH);
          if (on && xi > lx && xi < lx + int'(CELL_W) && yi > ly && yi < ly + int'(CELL_H)) begin
            hit1_d  = 1'b1;
            ent1_d  = EntW'(s * int'(NUM_CH) + c);
            dig1_d  = DigW'(d);
            addr1_d = 8'((yi - ly - 1) * int'(CELL_W - 1) + (xi - lx - 1));
          end
        end
      end
    end
  end

  // Stage 2 lookup: a digit is blanked when it and every more significant digit are zero.
  always_comb begin
    rd_dig    = bank_q[sel_q][ent1_q][dig1_q];
    lead_zero = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (d <= int'(dig1_q) && bank_q[sel_q][ent1_q][d] != 4'd0) lead_zero = 1'b0;
    end
    blanked = (BLANK_LZ != 0) && (int'(dig1_q) < int'(DIGITS) - 1) && lead_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit1_q       <= 1'b0;
      ent1_q       <= '0;
      dig1_q       <= '0;
      addr1_q      <= '0;
      pixel_active <= 1'b0;
      digit        <= 4'd0;
      glyph_addr   <= 8'd0;
    end else begin
      hit1_q  <= hit1_d;
      ent1_q  <= ent1_d;
      dig1_q  <= dig1_d;
      addr1_q <= addr1_d;
      if (hit1_q) begin
        pixel_active <= ~blanked;
        digit        <= rd_dig;
        glyph_addr   <= addr1_q;
      end else begin
        pixel_active <= 1'b0;
        digit        <= 4'd0;
        glyph_addr   <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_qos_stat_overlay.sv
// Bench for qos_stat_overlay: three instances (default, no leading-zero blanking, 12-bit
// counters) share pixel/frame stimulus; results are checked against a decimal-arithmetic model.
module tb_qos_stat_overlay;
  localparam int NE    = 12;
  localparam int NCH   = 4;
  localparam int DG    = 3;
  localparam int OX    = 366;
  localparam int OY    = 154;
  localparam int CP    = 60;
  localparam int RP    = 95;
  localparam int CW    = 10;
  localparam int CH    = 16;
  localparam int LEN_A = 121;
  localparam int LEN_C = 169;

  logic             clk = 1'b0;
  logic             rst, on, new_frame;
  logic [9:0]       x_loc, y_loc;
  logic [NE*8-1:0]  stats_a, stats_b;
  logic [NE*12-1:0] stats_c;
  logic             pa_a, pa_b, pa_c, busy_a, busy_b, busy_c;
  logic [3:0]       dg_a, dg_b, dg_c;
  logic [7:0]       ga_a, ga_b, ga_c, sk_a, sk_b, sk_c;

  int checks   = 0;
  int failures = 0;
  int sa[NE], sb[NE], sc[NE];   // values on the stats buses
  int fa[NE], fb[NE], fc[NE];   // values expected in the displayed bank
  int ka, kb, kc;               // expected skip counts

  typedef struct {
    int   x;
    int   y;
    logic o;
  } pix_t;
  pix_t pq[$];

  qos_stat_overlay dut_a (
    .clk(clk), .rst(rst), .on(on), .new_frame(new_frame), .x_loc(x_loc), .y_loc(y_loc),
    .stats(stats_a), .pixel_active(pa_a), .digit(dg_a), .glyph_addr(ga_a), .busy(busy_a),
    .skip_count(sk_a)
  );

  qos_stat_overlay #(.BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .on(on), .new_frame(new_frame), .x_loc(x_loc), .y_loc(y_loc),
    .stats(stats_b), .pixel_active(pa_b), .digit(dg_b), .glyph_addr(ga_b), .busy(busy_b),
    .skip_count(sk_b)
  );

  qos_stat_overlay #(.CNT_W(12)) dut_c (
    .clk(clk), .rst(rst), .on(on), .new_frame(new_frame), .x_loc(x_loc), .y_loc(y_loc),
    .stats(stats_c), .pixel_active(pa_c), .digit(dg_c), .glyph_addr(ga_c), .busy(busy_c),
    .skip_count(sk_c)
  );

  always #5 clk = ~clk;

  function automatic int pw10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int satv(input int v);
    return (v > pw10(DG) - 1) ? pw10(DG) - 1 : v;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int front_val(input int which, input int e);
    if (which == 0) return fa[e];
    if (which == 1) return fb[e];
    return fc[e];
  endfunction

  // Expected {pixel_active, digit, glyph_addr} for a pixel; which=1 is the non-blanking DUT.
  function automatic logic [12:0] model_pix(input int x, input int y, input logic o,
                                            input int which);
    logic [12:0] r;
    int          lx, ly, v, dv;
    logic        blank;
    r = '0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < NCH; c++) begin
        for (int d = 0; d < DG; d++) begin
          lx = OX + c * CP + d * CW;
          ly = OY + s * RP;
          if (o && x > lx && x < lx + CW && y > ly && y < ly + CH) begin
            v     = front_val(which, s * NCH + c);
            dv    = (v / pw10(DG - 1 - d)) % 10;
            blank = (which != 1) && (d < DG - 1) && (v < pw10(DG - 1 - d));
            r     = {~blank, 4'(dv), 8'((y - ly - 1) * (CW - 1) + (x - lx - 1))};
          end
        end
      end
    end
    return r;
  endfunction

  task automatic drive_stats();
    for (int e = 0; e < NE; e++) begin
      stats_a[e*8 +: 8]   = 8'(sa[e]);
      stats_b[e*8 +: 8]   = 8'(sb[e]);
      stats_c[e*12 +: 12] = 12'(sc[e]);
    end
  endtask

  task automatic rand_stats();
    for (int e = 0; e < NE; e++) begin
      sa[e] = int'($urandom_range(0, 255) >> $urandom_range(0, 7));
      sb[e] = int'($urandom_range(0, 255) >> $urandom_range(0, 7));
      sc[e] = int'($urandom_range(0, 4095) >> $urandom_range(0, 11));
    end
  endtask

  task automatic clear_model();
    for (int e = 0; e < NE; e++) begin
      fa[e] = 0;
      fb[e] = 0;
      fc[e] = 0;
    end
    ka = 0;
    kb = 0;
    kc = 0;
  endtask

  task automatic push_pix(input int x, input int y, input logic o);
    pix_t p;
    p.x = x;
    p.y = y;
    p.o = o;
    pq.push_back(p);
  endtask

  task automatic push_cell(input int e, input int d);
    push_pix(OX + (e % NCH) * CP + d * CW + 5, OY + (e / NCH) * RP + 8, 1'b1);
  endtask

  task automatic push_all_cells();
    for (int e = 0; e < NE; e++)
      for (int d = 0; d < DG; d++) push_cell(e, d);
  endtask

  task automatic push_random(input int n);
    int s, c, d, lx, ly;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        push_pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b1);
      end else begin
        s  = int'($urandom_range(0, 2));
        c  = int'($urandom_range(0, NCH - 1));
        d  = int'($urandom_range(0, DG - 1));
        lx = OX + c * CP + d * CW;
        ly = OY + s * RP;
        push_pix(lx - 1 + int'($urandom_range(0, CW + 1)), ly - 1 + int'($urandom_range(0, CH + 1)),
                 ($urandom_range(0, 7) != 0));
      end
    end
  endtask

  // One pixel per cycle; outputs sampled at a negedge belong to the pixel driven two negedges
  // earlier.
  task automatic run_stream(input int nrand);
    int          n;
    logic [12:0] ea[$], eb[$], ec[$];
    push_random(nrand);
    n = pq.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if ({pa_a, dg_a, ga_a} !== ea[i-2]) begin
          failures++;
          $display("FAIL pix_a x=%0d y=%0d on=%0b got=%h exp=%h", pq[i-2].x, pq[i-2].y,
                   pq[i-2].o, {pa_a, dg_a, ga_a}, ea[i-2]);
        end
        checks++;
        if ({pa_b, dg_b, ga_b} !== eb[i-2]) begin
          failures++;
          $display("FAIL pix_b x=%0d y=%0d on=%0b got=%h exp=%h", pq[i-2].x, pq[i-2].y,
                   pq[i-2].o, {pa_b, dg_b, ga_b}, eb[i-2]);
        end
        checks++;
        if ({pa_c, dg_c, ga_c} !== ec[i-2]) begin
          failures++;
          $display("FAIL pix_c x=%0d y=%0d on=%0b got=%h exp=%h", pq[i-2].x, pq[i-2].y,
                   pq[i-2].o, {pa_c, dg_c, ga_c}, ec[i-2]);
        end
      end
      if (i < n) begin
        x_loc = 10'(pq[i].x);
        y_loc = 10'(pq[i].y);
        on    = pq[i].o;
        ea.push_back(model_pix(pq[i].x, pq[i].y, pq[i].o, 0));
        eb.push_back(model_pix(pq[i].x, pq[i].y, pq[i].o, 1));
        ec.push_back(model_pix(pq[i].x, pq[i].y, pq[i].o, 2));
      end else begin
        on = 1'b0;
      end
    end
    pq.delete();
  endtask

  task automatic check_skip(input string tag);
    checks++;
    if (sk_a !== 8'(ka)) begin
      failures++;
      $display("FAIL %s skip_a got=%0d exp=%0d", tag, sk_a, ka);
    end
    checks++;
    if (sk_b !== 8'(kb)) begin
      failures++;
      $display("FAIL %s skip_b got=%0d exp=%0d", tag, sk_b, kb);
    end
    checks++;
    if (sk_c !== 8'(kc)) begin
      failures++;
      $display("FAIL %s skip_c got=%0d exp=%0d", tag, sk_c, kc);
    end
  endtask

  // Runs one conversion. Extra new_frame pulses go out on busy cycles nf1/nf2 and the stats
  // buses are re-randomised on busy cycle chg (0 = never).
  task automatic frame(input int nf1, input int nf2, input int chg);
    int ca[NE], cb[NE], cc[NE];
    int la, lb, lc, cyc;
    drive_stats();
    ca = sa;
    cb = sb;
    cc = sc;
    @(negedge clk) new_frame = 1'b1;
    @(negedge clk) new_frame = 1'b0;
    la  = 0;
    lb  = 0;
    lc  = 0;
    cyc = 1;
    while ((busy_a || busy_b || busy_c) && cyc < 600) begin
      la += int'(busy_a);
      lb += int'(busy_b);
      lc += int'(busy_c);
      if (cyc == chg) begin
        rand_stats();
        drive_stats();
      end
      new_frame = (cyc == nf1 || cyc == nf2);
      @(negedge clk);
      cyc++;
    end
    new_frame = 1'b0;
    checks++;
    if (la != LEN_A) begin
      failures++;
      $display("FAIL busy_len_a got=%0d exp=%0d", la, LEN_A);
    end
    checks++;
    if (lb != LEN_A) begin
      failures++;
      $display("FAIL busy_len_b got=%0d exp=%0d", lb, LEN_A);
    end
    checks++;
    if (lc != LEN_C) begin
      failures++;
      $display("FAIL busy_len_c got=%0d exp=%0d", lc, LEN_C);
    end
    if (nf1 > 0 && nf1 <= LEN_A) begin ka = sat255(ka + 1); kb = sat255(kb + 1); end
    if (nf2 > 0 && nf2 <= LEN_A) begin ka = sat255(ka + 1); kb = sat255(kb + 1); end
    if (nf1 > 0 && nf1 <= LEN_C) kc = sat255(kc + 1);
    if (nf2 > 0 && nf2 <= LEN_C) kc = sat255(kc + 1);
    check_skip("frame");
    for (int e = 0; e < NE; e++) begin
      fa[e] = satv(ca[e]);
      fb[e] = satv(cb[e]);
      fc[e] = satv(cc[e]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    on  = 1'b1;
    x_loc = 10'(OX + 2 * CW + 5);
    y_loc = 10'(OY + 8);
    repeat (3) @(negedge clk);
    checks++;
    if ({pa_a, dg_a, ga_a, busy_a, sk_a} !== 22'd0) begin
      failures++;
      $display("FAIL reset_a got=%h exp=0", {pa_a, dg_a, ga_a, busy_a, sk_a});
    end
    checks++;
    if ({pa_b, dg_b, ga_b, busy_b, sk_b} !== 22'd0) begin
      failures++;
      $display("FAIL reset_b got=%h exp=0", {pa_b, dg_b, ga_b, busy_b, sk_b});
    end
    checks++;
    if ({pa_c, dg_c, ga_c, busy_c, sk_c} !== 22'd0) begin
      failures++;
      $display("FAIL reset_c got=%h exp=0", {pa_c, dg_c, ga_c, busy_c, sk_c});
    end
    rst = 1'b0;
    on  = 1'b0;
    clear_model();
    push_all_cells();
    run_stream(40);
    check_skip("reset");
  endtask

  task automatic test_convert();
    rand_stats();
    sa[0] = 255; sa[1] = 7; sb[0] = 255; sb[1] = 7;
    sc[0] = 1500; sc[1] = 999; sc[2] = 1000; sc[3] = 7;
    frame(0, 0, 0);
    for (int e = 0; e < 4; e++)
      for (int d = 0; d < DG; d++) push_cell(e, d);
    run_stream(60);
  endtask

  task automatic test_boundaries();
    int lx, ly;
    for (int k = 0; k < 3; k++) begin
      lx = OX + ((k == 2) ? 3 * CP : 0) + ((k == 1) ? 2 * CW : 0);
      ly = OY + ((k == 2) ? 2 * RP : 0);
      push_pix(lx, ly + 5, 1'b1);
      push_pix(lx + 1, ly + 1, 1'b1);
      push_pix(lx + 9, ly + 15, 1'b1);
      push_pix(lx + 10, ly + 5, 1'b1);
      push_pix(lx + 5, ly, 1'b1);
      push_pix(lx + 5, ly + 16, 1'b1);
      push_pix(lx + 5, ly + 8, 1'b0);
    end
    run_stream(0);
  endtask

  task automatic test_skip();
    rand_stats();
    frame(10, 121, 5);
    push_all_cells();
    run_stream(20);
  endtask

  task automatic test_front_stable();
    int ca[NE], cb[NE], cc[NE];
    int cyc;
    rand_stats();
    drive_stats();
    ca = sa;
    cb = sb;
    cc = sc;
    @(negedge clk) new_frame = 1'b1;
    @(negedge clk) new_frame = 1'b0;
    push_all_cells();
    run_stream(10);
    cyc = 0;
    while ((busy_a || busy_b || busy_c) && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 600) begin
      failures++;
      $display("FAIL front_stable_timeout got=%0d exp<600", cyc);
    end
    for (int e = 0; e < NE; e++) begin
      fa[e] = satv(ca[e]);
      fb[e] = satv(cb[e]);
      fc[e] = satv(cc[e]);
    end
    push_all_cells();
    run_stream(10);
  endtask

  task automatic test_reset_abort();
    rand_stats();
    drive_stats();
    @(negedge clk) new_frame = 1'b1;
    @(negedge clk) new_frame = 1'b0;
    repeat (39) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_busy got=%b exp=1", busy_a);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b000) begin
      failures++;
      $display("FAIL abort_busy got=%b exp=000", {busy_a, busy_b, busy_c});
    end
    @(negedge clk) rst = 1'b0;
    clear_model();
    check_skip("abort");
    push_all_cells();
    run_stream(10);
    rand_stats();
    frame(0, 0, 0);
    push_all_cells();
    run_stream(10);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      rand_stats();
      frame(0, 0, 0);
      for (int e = 0; e < NE; e += 3) push_cell(e, 2);
      run_stream(15);
    end
  endtask

  initial begin
    rst       = 1'b1;
    on        = 1'b0;
    new_frame = 1'b0;
    x_loc     = '0;
    y_loc     = '0;
    stats_a   = '0;
    stats_b   = '0;
    stats_c   = '0;
    clear_model();
    test_reset();
    test_convert();
    test_boundaries();
    test_skip();
    test_front_stable();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
